usr_serial_rx: RTL and testbench
================================

# usr_serial_rx

Serial receiver for the far end of a universal-shift-register link. It samples the bit stream that a transmitting `usr` shifts out, using the transmitter's own `modesel` code as framing and direction. It reassembles each WIDTH-bit word in the original bit order and presents it on a valid/ready parallel port. The block sits downstream of the `usr` serial output and upstream of any parallel consumer.

## Interface
- `WIDTH`, default 4: word length in bits; must be ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset; `reset`=0 clears all state immediately.
- `Sin` in 1: serial data bit from the transmitter's shift-out end.
- `modesel` in 2: transmitter mode, same encoding as `usr`:
  - 00 = hold
  - 01 = shift right (LSB-first)
  - 10 = shift left (MSB-first)
  - 11 = parallel load (start of frame)
- `Pout` out WIDTH: received word.
- `Pvalid` out 1: `Pout` holds an unconsumed word.
- `Pready` in 1: consumer accepts `Pout` when `Pvalid` && `Pready` at a clock edge.
- `busy` out 1: frame in progress (state RECV).
- `abort` out 1: one-cycle pulse; partial frame discarded by a new load.
- `dir_err` out 1: one-cycle pulse; frame discarded because the shift direction changed mid-word.
- `overrun` out 1: sticky; a completed word was dropped because the output buffer was full. Cleared only by reset.

## Operation
- Reset values: `Pout`=0, `Pvalid`=0, `busy`=0, `abort`=0, `dir_err`=0, `overrun`=0. Internally, state=IDLE, count=0, shift register=0.
- **IDLE:**
  - `modesel` 11 → RECV, count=0, direction unlocked.
  - All other codes are ignored; unframed bits are never sampled.
- **RECV:**
  - 00: hold. No sample, count unchanged.
  - 01 or 10 with count=0: lock direction to this code, then sample.
  - 01 or 10 matching the locked direction: sample, count+1.
  - Shift code opposite to the locked direction: discard the frame, pulse `dir_err`, → IDLE.
  - 11: restart. count=0, direction unlocked, stay in RECV. Pulse `abort` only if count>0.
- **Sampling:**
  - 01: sr ← {Sin, sr[WIDTH-1:1]}.
  - 10: sr ← {sr[WIDTH-2:0], Sin}.
  - Either way, the completed word equals the word loaded into the transmitter.
- **Completion:** on the edge that samples bit WIDTH, the word is offered to the output buffer and the FSM → IDLE. A new frame needs a new 11.
- **Output buffer:**
  - If the buffer is empty, or is being consumed on the same edge (`Pvalid`&&`Pready`): `Pout` ← word, `Pvalid`=1.
  - Otherwise the new word is dropped, `Pout` is kept, and `overrun` is set.
- Consumption without a new word: `Pvalid`→0 at the next edge; `Pout` retains its value.
- Counter width is $clog2(WIDTH+1); it never exceeds WIDTH.

## Timing
- `Sin` is sampled on the same edge on which the transmitter applies the shift code. The receiver and transmitter share `clk` and `modesel`.
- Latency: `Pvalid` rises the cycle after the edge that samples bit WIDTH. Minimum is WIDTH+1 edges after the load edge, with no hold cycles.
- Back-to-back frames: 11 may occur on the edge right after completion. Throughput is one word per WIDTH+1 cycles.
- Completion and consume on the same edge: `Pvalid` stays 1 and `Pout` takes the new word, with no overrun.
- `abort` and `dir_err` are high for exactly the cycle after the triggering edge.
- Async reset mid-frame: the partial word is lost. After `reset` deassertion, the block is in IDLE and needs a new 11.

## Structure
- Package `usr_pkg`:
  - `usr_mode_e` (MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11), shared with `usr`.
  - `usr_rx_state_e` (IDLE, RECV).
- Sub-module `usr_rx_outbuf`: WIDTH-bit holding register plus the valid/ready/overrun logic. The top level contains the FSM, counter and shift register.

## Test plan
- MSB-first, WIDTH=4: 11, then 10×4 with `Sin`=1,1,0,1, `Pready`=1 → `Pout`=4'b1101 and `Pvalid`=1 one cycle after the 4th shift, for one cycle.
- LSB-first with holds: 11, then 01/`Sin`=1, 00, 01/0, 00, 00, 01/1, 01/1 → `Pout`=4'b1101. `busy` stays high through the holds; no error pulses.
- Overrun: `Pready`=0; send 4'b1101, then 4'b1111 → `Pout` stays 1101 and `overrun`=1. Then raise `Pready` → `Pvalid`=0 after one edge; `overrun` stays 1.
- Abort and direction error:
  - 11, 10×2, 11 → `abort` pulses; then 10×4 `Sin`=1,1,1,1 yields 4'b1111.
  - 11, 10, 01 → `dir_err` pulses, FSM returns to IDLE, `Pvalid` stays 0.
- Reset mid-frame: pulse `reset`=0 after 2 of 4 shifts → all outputs 0 immediately. Subsequent shifts without 11 produce no word.
- Back-to-back: two frames (1101, then 0110) with 11 on the edge right after completion, `Pready`=1 → two `Pvalid` pulses WIDTH+1 cycles apart, correct data, no overrun.

Source files
------------

// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
//   Types shared by the universal shift register (usr) and its serial
//   receiver (usr_serial_rx).
//   - usr_mode_e     : modesel encoding, identical on both ends of the link
//   - usr_rx_state_e : receiver framing state
// -----------------------------------------------------------------------------
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,  // no shift
    MODE_SHR  = 2'b01,  // shift right, LSB leaves first
    MODE_SHL  = 2'b10,  // shift left, MSB leaves first
    MODE_LOAD = 2'b11   // parallel load, marks start of frame
  } usr_mode_e;

  typedef enum logic {
    IDLE = 1'b0,        // waiting for a load code
    RECV = 1'b1         // frame in progress
  } usr_rx_state_e;

endpackage : usr_pkg

// File: rtl/usr_rx_outbuf.sv
// -----------------------------------------------------------------------------
// usr_rx_outbuf
//   Single-entry output buffer for the serial receiver. Holds one completed
//   word and hands it out over a valid/ready handshake.
//   Ports:
//     clk, rst_n        : clock, asynchronous active-low reset
//     word_valid, word  : completed word offered on this edge
//     pready            : consumer accepts pout when pvalid && pready
//     pout, pvalid      : buffered word and its valid flag
//     overrun           : sticky, a completed word was dropped (buffer full)
// -----------------------------------------------------------------------------
module usr_rx_outbuf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_valid,
  input  logic [WIDTH-1:0] word,
  input  logic             pready,
  output logic [WIDTH-1:0] pout,
  output logic             pvalid,
  output logic             overrun
);

  // A slot is free if it is empty or being drained on this very edge, which
  // lets a completion and a consume coincide without losing the new word.
  logic slot_free;
  assign slot_free = !pvalid || pready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout    <= '0;
      pvalid  <= 1'b0;
      overrun <= 1'b0;
    end else if (word_valid) begin
      if (slot_free) begin
        pout   <= word;
        pvalid <= 1'b1;
      end else begin
        overrun <= 1'b1;  // pout is kept; the new word is lost
      end
    end else if (pvalid && pready) begin
      pvalid <= 1'b0;     // pout keeps its last value
    end
  end

endmodule : usr_rx_outbuf

// File: rtl/usr_serial_rx.sv
// -----------------------------------------------------------------------------
// usr_serial_rx
//   Receives the serial stream shifted out by a usr transmitter, using the
//   transmitter's modesel as framing (11 = start) and direction (01 = LSB
//   first, 10 = MSB first). Each WIDTH-bit word is rebuilt in its original bit
//   order and presented on a valid/ready parallel port.
//   Ports:
//     clk, reset        : clock, asynchronous active-low reset
//     Sin, modesel      : serial bit and transmitter mode, sampled together
//     Pout, Pvalid      : received word and valid flag
//     Pready            : consumer ready
//     busy              : frame in progress
//     abort             : 1-cycle pulse, partial frame discarded by a reload
//     dir_err           : 1-cycle pulse, frame discarded on direction change
//     overrun           : sticky, completed word dropped (buffer full)
// -----------------------------------------------------------------------------
module usr_serial_rx
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Sin,
  input  logic [1:0]       modesel,
  output logic [WIDTH-1:0] Pout,
  output logic             Pvalid,
  input  logic             Pready,
  output logic             busy,
  output logic             abort,
  output logic             dir_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  usr_rx_state_e    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  usr_mode_e        dir_q, dir_d;
  logic             abort_d, dir_err_d;
  logic             word_done;
  usr_mode_e        mode;

  assign mode = usr_mode_e'(modesel);

  // Direction is "unlocked" whenever count is zero: the first shift of a
  // frame (re)locks it, so no separate lock flag is needed.
  // NOTE: every signal driven here gets a default first; otherwise a path
  // that leaves one unassigned infers a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sr_d      = sr_q;
    dir_d     = dir_q;
    abort_d   = 1'b0;
    dir_err_d = 1'b0;
    word_done = 1'b0;

    case (state_q)
      IDLE: begin
        // Unframed shift codes are ignored; only a load opens a frame.
        if (mode == MODE_LOAD) begin
          state_d = RECV;
          count_d = '0;
        end
      end

      RECV: begin
        case (mode)
          MODE_SHR, MODE_SHL: begin
            if (count_q != '0 && mode != dir_q) begin
              dir_err_d = 1'b1;
              state_d   = IDLE;
              count_d   = '0;
            end else begin
              dir_d = mode;
              if (mode == MODE_SHR) sr_d = {Sin, sr_q[WIDTH-1:1]};
              else                  sr_d = {sr_q[WIDTH-2:0], Sin};
              if (count_q == LAST_BIT) begin
                word_done = 1'b1;
                state_d   = IDLE;
                count_d   = '0;
              end else begin
                count_d = count_q + CW'(1);
              end
            end
          end
          MODE_LOAD: begin
            count_d = '0;
            abort_d = (count_q != '0);
          end
          default: ;  // hold: no sample, count unchanged
        endcase
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      sr_q    <= '0;
      dir_q   <= MODE_HOLD;
      abort   <= 1'b0;
      dir_err <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sr_q    <= sr_d;
      dir_q   <= dir_d;
      abort   <= abort_d;
      dir_err <= dir_err_d;
    end
  end

  assign busy = (state_q == RECV);

  // The completed word is sr_d, so it reaches the buffer on the same edge
  // that samples the last bit.
  usr_rx_outbuf #(.WIDTH(WIDTH)) u_outbuf (
    .clk        (clk),
    .rst_n      (reset),
    .word_valid (word_done),
    .word       (sr_d),
    .pready     (Pready),
    .pout       (Pout),
    .pvalid     (Pvalid),
    .overrun    (overrun)
  );

endmodule : usr_serial_rx

// File: tb/tb_usr_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_usr_serial_rx
//   Directed self-checking bench for usr_serial_rx with WIDTH=4. Inputs change
//   1 time unit after a rising edge; outputs are compared at the same point.
// -----------------------------------------------------------------------------
module tb_usr_serial_rx;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             Sin;
  logic [1:0]       modesel;
  logic [WIDTH-1:0] Pout;
  logic             Pvalid;
  logic             Pready;
  logic             busy;
  logic             abort;
  logic             dir_err;
  logic             overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  usr_serial_rx #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .Sin     (Sin),
    .modesel (modesel),
    .Pout    (Pout),
    .Pvalid  (Pvalid),
    .Pready  (Pready),
    .busy    (busy),
    .abort   (abort),
    .dir_err (dir_err),
    .overrun (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One clock: apply mode and bit, advance to just after the edge.
  task automatic step(input logic [1:0] m, input logic s);
    modesel = m;
    Sin     = s;
    @(posedge clk);
    #1;
  endtask

  // Load, then WIDTH shifts in the given direction; bit order chosen so the
  // rebuilt word equals w.
  task automatic send_frame(input logic [1:0] m, input logic [WIDTH-1:0] w);
    step(2'b11, 1'b0);
    for (int i = 0; i < WIDTH; i++)
      step(m, (m == 2'b10) ? w[WIDTH-1-i] : w[i]);
  endtask

  task automatic do_reset();
    modesel = 2'b00;
    Sin     = 1'b0;
    Pready  = 1'b0;
    reset   = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Pout, Pvalid, busy, abort, dir_err, overrun} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b",
               {Pout, Pvalid, busy, abort, dir_err, overrun}, 9'b0);
    end
  endtask

  task automatic test_msb_first();
    do_reset();
    Pready = 1'b1;
    send_frame(2'b10, 4'b1101);
    checks++;
    if (Pvalid !== 1'b1 || Pout !== 4'b1101) begin
      errors++;
      $display("FAIL msb_word: Pvalid=%b Pout=%b expected 1 1101", Pvalid, Pout);
    end
    step(2'b00, 1'b0);
    checks++;
    if (Pvalid !== 1'b0 || Pout !== 4'b1101 || busy !== 1'b0) begin
      errors++;
      $display("FAIL msb_one_cycle: Pvalid=%b Pout=%b busy=%b expected 0 1101 0",
               Pvalid, Pout, busy);
    end
  endtask

  task automatic test_lsb_holds();
    logic [1:0] m [8] = '{2'b11, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    logic       s [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    int bad = 0;
    do_reset();
    Pready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(m[i], s[i]);
      if (abort !== 1'b0 || dir_err !== 1'b0) bad++;
      if (i < 7 && (busy !== 1'b1 || Pvalid !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lsb_hold_flags: %0d bad cycles expected 0", bad);
    end
    checks++;
    if (Pvalid !== 1'b1 || Pout !== 4'b1101 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lsb_word: Pvalid=%b Pout=%b busy=%b expected 1 1101 0",
               Pvalid, Pout, busy);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(2'b10, 4'b1101);
    checks++;
    if (Pvalid !== 1'b1 || Pout !== 4'b1101 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first: Pvalid=%b Pout=%b overrun=%b expected 1 1101 0",
               Pvalid, Pout, overrun);
    end
    send_frame(2'b10, 4'b1111);
    checks++;
    if (Pvalid !== 1'b1 || Pout !== 4'b1101 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drop: Pvalid=%b Pout=%b overrun=%b expected 1 1101 1",
               Pvalid, Pout, overrun);
    end
    Pready = 1'b1;
    step(2'b00, 1'b0);
    checks++;
    if (Pvalid !== 1'b0 || Pout !== 4'b1101 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drain: Pvalid=%b Pout=%b overrun=%b expected 0 1101 1",
               Pvalid, Pout, overrun);
    end
  endtask

  task automatic test_abort();
    do_reset();
    Pready = 1'b1;
    step(2'b11, 1'b0);
    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    step(2'b11, 1'b0);
    checks++;
    if (abort !== 1'b1 || busy !== 1'b1 || Pvalid !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: abort=%b busy=%b Pvalid=%b expected 1 1 0",
               abort, busy, Pvalid);
    end
    for (int i = 0; i < WIDTH; i++) begin
      step(2'b10, 1'b1);
      if (i == 0) begin
        checks++;
        if (abort !== 1'b0) begin
          errors++;
          $display("FAIL abort_width: abort=%b expected 0", abort);
        end
      end
    end
    checks++;
    if (Pvalid !== 1'b1 || Pout !== 4'b1111) begin
      errors++;
      $display("FAIL abort_refill: Pvalid=%b Pout=%b expected 1 1111", Pvalid, Pout);
    end
  endtask

  task automatic test_dir_err();
    do_reset();
    Pready = 1'b1;
    step(2'b11, 1'b0);
    step(2'b10, 1'b1);
    step(2'b01, 1'b1);
    checks++;
    if (dir_err !== 1'b1 || busy !== 1'b0 || Pvalid !== 1'b0 || abort !== 1'b0) begin
      errors++;
      $display("FAIL dir_err_pulse: dir_err=%b busy=%b Pvalid=%b abort=%b expected 1 0 0 0",
               dir_err, busy, Pvalid, abort);
    end
    step(2'b01, 1'b1);
    checks++;
    if (dir_err !== 1'b0 || busy !== 1'b0 || Pvalid !== 1'b0) begin
      errors++;
      $display("FAIL dir_err_idle: dir_err=%b busy=%b Pvalid=%b expected 0 0 0",
               dir_err, busy, Pvalid);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    do_reset();
    send_frame(2'b10, 4'b1101);  // leave a pending word in the buffer
    send_frame(2'b10, 4'b1111);  // and set overrun
    step(2'b11, 1'b0);
    step(2'b10, 1'b1);
    step(2'b10, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({Pout, Pvalid, busy, abort, dir_err, overrun} !== 9'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected %b",
               {Pout, Pvalid, busy, abort, dir_err, overrun}, 9'b0);
    end
    @(posedge clk);
    #1;
    reset  = 1'b1;
    Pready = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step(2'b10, 1'b1);
      if (busy !== 1'b0 || Pvalid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL unframed_ignored: %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int t1 = -1;
    int t2 = -1;
    int pulses = 0;
    do_reset();
    Pready = 1'b1;
    send_frame(2'b10, 4'b1101);
    if (Pvalid === 1'b1) begin t1 = cyc; pulses++; end
    checks++;
    if (Pout !== 4'b1101) begin
      errors++;
      $display("FAIL b2b_word1: Pout=%b expected 1101", Pout);
    end
    step(2'b11, 1'b0);
    if (Pvalid === 1'b1) pulses++;
    for (int i = 0; i < WIDTH; i++) begin
      step(2'b10, (4'b0110 >> (WIDTH-1-i)) & 1);
      if (Pvalid === 1'b1) begin t2 = cyc; pulses++; end
    end
    checks++;
    if (Pout !== 4'b0110 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_word2: Pout=%b overrun=%b expected 0110 0", Pout, overrun);
    end
    checks++;
    if (pulses != 2 || t2 - t1 != WIDTH + 1) begin
      errors++;
      $display("FAIL b2b_spacing: pulses=%0d gap=%0d expected 2 %0d",
               pulses, t2 - t1, WIDTH + 1);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    send_frame(2'b10, 4'b1101);
    step(2'b11, 1'b0);
    step(2'b10, 1'b0);
    step(2'b10, 1'b1);
    step(2'b10, 1'b1);
    Pready = 1'b1;
    step(2'b10, 1'b0);
    checks++;
    if (Pvalid !== 1'b1 || Pout !== 4'b0110 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL same_edge: Pvalid=%b Pout=%b overrun=%b expected 1 0110 0",
               Pvalid, Pout, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_holds();
    test_overrun();
    test_abort();
    test_dir_err();
    test_async_reset();
    test_back_to_back();
    test_same_edge();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_usr_serial_rx
